// File: rtl/encoder_pkg.sv
// Shared widths and encoding helpers for the 8-to-3 binary encoder.
// Both priority directions and the multi-hot detector live here so the core stays a thin wrapper.
package encoder_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  // Index of the winning request line; prio_msb selects highest (1) or lowest (0) set bit.
  function automatic logic [ENC_OUT_W-1:0] onehot_to_idx(
    input logic [ENC_IN_W-1:0] vec,
    input logic                prio_msb
  );
    logic [ENC_OUT_W-1:0] idx;
    idx = {ENC_OUT_W{1'b0}};
    if (prio_msb) begin
      // Ascending scan: the last set bit seen is the highest one.
      for (int i = 0; i < ENC_IN_W; i++) begin
        if (vec[i]) begin
          idx = ENC_OUT_W'(i);
        end else begin
          idx = idx;
        end
      end
    end else begin
      // Descending scan: the last set bit seen is the lowest one.
      for (int i = ENC_IN_W - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = ENC_OUT_W'(i);
        end else begin
          idx = idx;
        end
      end
    end
    return idx;
  endfunction

  // True when at least two request lines are set: OR over every distinct pair.
  function automatic logic is_multi_hot(input logic [ENC_IN_W-1:0] vec);
    logic multi;
    multi = 1'b0;
    for (int i = 0; i < ENC_IN_W - 1; i++) begin
      for (int j = i + 1; j < ENC_IN_W; j++) begin
        multi = multi | (vec[i] & vec[j]);
      end
    end
    return multi;
  endfunction

endpackage

// File: rtl/encoder_8to3_core.sv
// Combinational encode stage: index, any-request and multi-request flags for one request vector.
module encoder_8to3_core
  import encoder_pkg::*;
#(
  parameter bit PRIORITY_MSB = 1'b1
) (
  input  logic [ENC_IN_W-1:0]  y,
  output logic [ENC_OUT_W-1:0] a_nxt,
  output logic                 valid_nxt,
  output logic                 multi_hot_nxt
);

  logic [ENC_OUT_W-1:0] idx_s;
  logic                 valid_s;
  logic                 multi_s;

  // Encode; an empty vector reports index 0 with valid low.
  always_comb begin
    idx_s   = {ENC_OUT_W{1'b0}};
    valid_s = |y;
    multi_s = is_multi_hot(y);
    if (valid_s) begin
      idx_s = onehot_to_idx(y, PRIORITY_MSB);
    end else begin
      idx_s = {ENC_OUT_W{1'b0}};
    end
  end

  assign a_nxt         = idx_s;
  assign valid_nxt     = valid_s;
  assign multi_hot_nxt = multi_s;

endmodule

// File: rtl/encoder_8to3.sv
// 8-to-3 encoder with one cycle of latency: async-reset register stage around the encode core.
module encoder_8to3
  import encoder_pkg::*;
#(
  parameter bit PRIORITY_MSB = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENC_IN_W-1:0]  y,
  output logic [ENC_OUT_W-1:0] a,
  output logic                 valid,
  output logic                 multi_hot
);

  logic [ENC_OUT_W-1:0] a_nxt_s;
  logic                 valid_nxt_s;
  logic                 multi_hot_nxt_s;
  logic [ENC_OUT_W-1:0] a_r;
  logic                 valid_r;
  logic                 multi_hot_r;

  encoder_8to3_core #(
    .PRIORITY_MSB (PRIORITY_MSB)
  ) u_core (
    .y             (y),
    .a_nxt         (a_nxt_s),
    .valid_nxt     (valid_nxt_s),
    .multi_hot_nxt (multi_hot_nxt_s)
  );

  // Output registers; reset clears them immediately and drops any pending sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= {ENC_OUT_W{1'b0}};
      valid_r     <= 1'b0;
      multi_hot_r <= 1'b0;
    end else begin
      a_r         <= a_nxt_s;
      valid_r     <= valid_nxt_s;
      multi_hot_r <= multi_hot_nxt_s;
    end
  end

  assign a         = a_r;
  assign valid     = valid_r;
  assign multi_hot = multi_hot_r;

endmodule

// File: tb/tb_encoder_8to3.sv
// Scoreboard bench for encoder_8to3: one instance per priority setting, same stimulus to both.
module tb_encoder_8to3;
  import encoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] y;
  logic [2:0] a_hi, a_lo;
  logic       valid_hi, valid_lo, mh_hi, mh_lo;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] a_hi;
    logic [2:0] a_lo;
    logic       valid;
    logic       multi;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  encoder_8to3 #(.PRIORITY_MSB(1'b1)) u_dut_hi (
    .clk(clk), .rst(rst), .y(y), .a(a_hi), .valid(valid_hi), .multi_hot(mh_hi)
  );

  encoder_8to3 #(.PRIORITY_MSB(1'b0)) u_dut_lo (
    .clk(clk), .rst(rst), .y(y), .a(a_lo), .valid(valid_lo), .multi_hot(mh_lo)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [7:0] yv, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s y=%02h: got %0d, want %0d", name, yv, act, req);
    end
  endfunction

  function automatic exp_t mk(logic [7:0] yv, int ahi, int alo, int val, int mh);
    exp_t e;
    e.y     = yv;
    e.a_hi  = 3'(ahi);
    e.a_lo  = 3'(alo);
    e.valid = 1'(val);
    e.multi = 1'(mh);
    return e;
  endfunction

  // Reference: popcount for the flags, first/last set bit scan for the indices.
  function automatic exp_t ref_model(logic [7:0] yv);
    int hi, lo, cnt;
    hi = 0; lo = 0; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (yv[i]) begin
        if (cnt == 0) lo = i;
        hi = i;
        cnt++;
      end
    end
    return mk(yv, hi, lo, (cnt >= 1) ? 1 : 0, (cnt >= 2) ? 1 : 0);
  endfunction

  task automatic drive(logic [7:0] v, exp_t e);
    @(negedge clk);
    y = v;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(string name);
    check({name, "_a_hi"},  y, int'(a_hi),     0);
    check({name, "_v_hi"},  y, int'(valid_hi), 0);
    check({name, "_mh_hi"}, y, int'(mh_hi),    0);
    check({name, "_a_lo"},  y, int'(a_lo),     0);
    check({name, "_v_lo"},  y, int'(valid_lo), 0);
    check({name, "_mh_lo"}, y, int'(mh_lo),    0);
  endtask

  // Monitor: every captured sample shows up 1 cycle later; pop its expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_hi",  e.y, int'(a_hi),     int'(e.a_hi));
        check("a_lo",  e.y, int'(a_lo),     int'(e.a_lo));
        check("v_hi",  e.y, int'(valid_hi), int'(e.valid));
        check("v_lo",  e.y, int'(valid_lo), int'(e.valid));
        check("mh_hi", e.y, int'(mh_hi),    int'(e.multi));
        check("mh_lo", e.y, int'(mh_lo),    int'(e.multi));
      end
    end
  end

  initial begin
    rst = 1'b1;
    y   = 8'hFF;
    #1;
    check_reset_state("rst_now");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_state("rst_hold");
    end

    // Release reset with an empty request vector.
    @(negedge clk);
    y   = 8'h00;
    rst = 1'b0;
    exp_q.push_back(mk(8'h00, 0, 0, 0, 0));

    drive(8'h01, mk(8'h01, 0, 0, 1, 0));
    drive(8'h02, mk(8'h02, 1, 1, 1, 0));
    drive(8'h04, mk(8'h04, 2, 2, 1, 0));
    drive(8'h08, mk(8'h08, 3, 3, 1, 0));
    drive(8'h10, mk(8'h10, 4, 4, 1, 0));
    drive(8'h20, mk(8'h20, 5, 5, 1, 0));
    drive(8'h40, mk(8'h40, 6, 6, 1, 0));
    drive(8'h80, mk(8'h80, 7, 7, 1, 0));
    drive(8'b1010_0100, mk(8'b1010_0100, 7, 2, 1, 1));
    drive(8'hFF, mk(8'hFF, 7, 0, 1, 1));
    drive(8'h00, mk(8'h00, 0, 0, 0, 0));

    // Async reset between edges while a result is held.
    drive(8'h40, mk(8'h40, 6, 6, 1, 0));
    @(posedge clk);
    #2;
    y   = 8'h10;
    rst = 1'b1;
    #1;
    check_reset_state("rst_async");
    @(posedge clk);
    #1;
    check_reset_state("rst_async_hold");
    @(negedge clk);
    y   = 8'h08;
    rst = 1'b0;
    exp_q.push_back(mk(8'h08, 3, 3, 1, 0));

    for (int v = 0; v < 256; v++) begin
      drive(8'(v), ref_model(8'(v)));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    check("drain", 8'h00, exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
